alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
//  Execute-stage ALU with built-in op decode. Next generation of ALU control:
//  decodes alu_op/funct3/funct7 into a 4-bit alu_ctrl code, executes the op on
//  XLEN-bit operands and registers the result. Adds iterative MUL, illegal-op
//  flagging and valid/ready handshakes on both sides.
//  Sits between register-read (ID/EX) and memory/writeback.
// PARAMETERS
//  XLEN    32  operand/result width; must be a power of 2, >= 8
//  MUL_EN  1   1: MUL is decoded and executed; 0: MUL decodes as illegal
// PORTS
//  clk       in   1     clock; all state updates on rising edge
//  rst_n     in   1     synchronous reset, active low
//  in_valid  in   1     op_a/op_b/decode fields valid
//  in_ready  out  1     unit can accept an op this cycle
//  alu_op    in   2     00 load/store add; 01 branch sub; 10 R-type; 11 reserved
//  funct3    in   3     instruction funct3
//  funct7_5  in   1     instr[30]: SUB/SRA select
//  funct7_0  in   1     instr[25]: M-extension select
//  op_a      in   XLEN  operand A
//  op_b      in   XLEN  operand B
//  out_valid out  1     result/flags valid
//  out_ready in   1     consumer takes the result this cycle
//  result    out  XLEN  registered result
//  zero      out  1     result == 0 (used for branch equal)
//  alu_ctrl  out  4     registered decoded op code
//  illegal   out  1     decoded op unsupported; result forced to 0
//  busy      out  1     high while in MUL state
// BEHAVIOUR
//  Reset: state=IDLE; result=0, alu_ctrl=0, zero=0, illegal=0, out_valid=0, busy=0.
//   Reset asserted in any state aborts the op; the aborted op produces no output.
//  Decode, sampled at accept (alu_ctrl code in brackets):
//   alu_op=00 ADD(0010). alu_op=01 SUB(0110). alu_op=11 illegal(1111).
//   alu_op=10 with funct7_0=0: funct3 000 ADD(0010) or SUB(0110) if funct7_5=1;
//   111 AND(0000); 110 OR(0001); 100 XOR(0111); 001 SLL(0011); 101 SRL(0100)
//   or SRA(0101) if funct7_5=1; 010 SLT(1000); 011 SLTU(1001).
//   alu_op=10 with funct7_0=1: funct3=000 and MUL_EN=1 -> MUL(1010);
//   any other combination -> illegal(1111).
//  Arithmetic: ADD/SUB wrap modulo 2^XLEN. Shift amount is op_b[$clog2(XLEN)-1:0].
//   SRA sign-fills. SLT is signed, SLTU unsigned; both give a 0/1 result.
//   MUL returns the low XLEN bits of the product; signed and unsigned give the same bits.
//  FSM states: IDLE, MUL, DONE.
//   in_ready = (state==IDLE) | (state==DONE & out_ready).
//   Accept = in_valid & in_ready.
//   Accept, single-cycle or illegal op -> DONE. Result is registered, out_valid=1
//   the next cycle. Latency is 1.
//   Accept, MUL -> MUL state; busy=1. Shift-add uses one multiplier bit per cycle,
//   LSB first, over XLEN cycles, then -> DONE. Latency is XLEN+1 from accept.
//   Operands are captured at accept; later input changes are ignored.
//   DONE: result, zero, alu_ctrl and illegal hold stable while out_valid & !out_ready.
//   DONE & out_ready & !accept -> IDLE, out_valid=0.
//   DONE & out_ready & accept: back-to-back op, the next output follows the
//   normal latency. Single-cycle ops sustain 1 op/cycle.
//   MUL state: in_ready=0 and out_valid=0, regardless of in_valid.
//  zero is computed from the registered result, so illegal ops give zero=1.
// TESTING (XLEN=32, MUL_EN=1)
//  alu_op=00, a=5, b=7, out_ready=1 -> 1 cycle later result=12, alu_ctrl=0010, zero=0.
//  alu_op=01, a=b=0x1234 -> result=0, zero=1, alu_ctrl=0110.
//  alu_op=10, funct3=101, funct7_5=1, a=0x80000000, b=4 -> result=0xF8000000.
//  MUL, a=0xFFFFFFFF, b=3 -> busy for 32 cycles, in_ready=0; result=0xFFFFFFFD, latency 33.
//  out_ready=0 for 5 cycles after a valid result -> result stable, in_ready=0;
//   then 3 back-to-back ADDs -> 3 results on consecutive cycles.
//  rst_n=0 at MUL cycle 10 -> next cycle IDLE, all outputs 0, no result emitted;
//   alu_op=11 -> illegal=1, result=0, alu_ctrl=1111.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Execute-stage ALU: decodes alu_op/funct3/funct7 into a 4-bit control code, runs
// single-cycle ops in one cycle and MUL as an XLEN-cycle shift-add, and presents a
// registered result behind valid/ready handshakes on both sides.
module alu_exec_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned SW = $clog2(XLEN);

  localparam logic [3:0] CtrlAnd  = 4'b0000;
  localparam logic [3:0] CtrlOr   = 4'b0001;
  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlSll  = 4'b0011;
  localparam logic [3:0] CtrlSrl  = 4'b0100;
  localparam logic [3:0] CtrlSra  = 4'b0101;
  localparam logic [3:0] CtrlSub  = 4'b0110;
  localparam logic [3:0] CtrlXor  = 4'b0111;
  localparam logic [3:0] CtrlSlt  = 4'b1000;
  localparam logic [3:0] CtrlSltu = 4'b1001;
  localparam logic [3:0] CtrlMul  = 4'b1010;
  localparam logic [3:0] CtrlIll  = 4'b1111;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      dec_ctrl;
  logic            dec_mul;
  logic            accept;
  logic            mul_last;
  logic [XLEN-1:0] exec_res;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] acc_q, mcand_q, mplier_q, acc_next;
  logic [SW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q, illegal_q;
  logic [3:0]      alu_ctrl_q;

  // Decode the instruction fields into the control code.
  always_comb begin
    dec_ctrl = CtrlIll;
    unique case (alu_op)
      2'b00: dec_ctrl = CtrlAdd;
      2'b01: dec_ctrl = CtrlSub;
      2'b10: begin
        if (funct7_0) begin
          if (funct3 == 3'b000 && MUL_EN) dec_ctrl = CtrlMul;
        end else begin
          unique case (funct3)
            3'b000: dec_ctrl = funct7_5 ? CtrlSub : CtrlAdd;
            3'b111: dec_ctrl = CtrlAnd;
            3'b110: dec_ctrl = CtrlOr;
            3'b100: dec_ctrl = CtrlXor;
            3'b001: dec_ctrl = CtrlSll;
            3'b101: dec_ctrl = funct7_5 ? CtrlSra : CtrlSrl;
            3'b010: dec_ctrl = CtrlSlt;
            3'b011: dec_ctrl = CtrlSltu;
            default: dec_ctrl = CtrlIll;
          endcase
        end
      end
      default: dec_ctrl = CtrlIll;
    endcase
  end

  assign dec_mul = (dec_ctrl == CtrlMul);
  assign shamt   = op_b[SW-1:0];

  // Single-cycle datapath; MUL and illegal ops produce 0 here.
  always_comb begin
    exec_res = '0;
    unique case (dec_ctrl)
      CtrlAdd:  exec_res = op_a + op_b;
      CtrlSub:  exec_res = op_a - op_b;
      CtrlAnd:  exec_res = op_a & op_b;
      CtrlOr:   exec_res = op_a | op_b;
      CtrlXor:  exec_res = op_a ^ op_b;
      CtrlSll:  exec_res = op_a << shamt;
      CtrlSrl:  exec_res = op_a >> shamt;
      CtrlSra:  exec_res = $unsigned($signed(op_a) >>> shamt);
      CtrlSlt:  exec_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CtrlSltu: exec_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  exec_res = '0;
    endcase
  end

  assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept   = in_valid & in_ready;
  assign mul_last = (state_q == StMul) && (cnt_q == SW'(XLEN - 1));
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = dec_mul ? StMul : StDone;
      StMul:  if (mul_last) state_d = StDone;
      StDone: begin
        if (out_ready) begin
          if (accept) state_d = dec_mul ? StMul : StDone;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Operand capture, shift-add iteration and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
      alu_ctrl_q <= 4'b0000;
    end else if (accept) begin
      alu_ctrl_q <= dec_ctrl;
      illegal_q  <= (dec_ctrl == CtrlIll);
      if (dec_mul) begin
        acc_q    <= '0;
        mcand_q  <= op_a;
        mplier_q <= op_b;
        cnt_q    <= '0;
      end else begin
        result_q <= exec_res;
        zero_q   <= (exec_res == '0);
      end
    end else if (state_q == StMul) begin
      // One multiplier bit per cycle, LSB first.
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + SW'(1);
      if (mul_last) begin
        result_q <= acc_next;
        zero_q   <= (acc_next == '0);
      end
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StMul);
  assign result    = result_q;
  assign zero      = zero_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, funct7_5, funct7_0;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic        out_valid, out_ready, zero, illegal, busy;
  logic [3:0]  alu_ctrl;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.XLEN(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .alu_ctrl(alu_ctrl), .illegal(illegal), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Model: cycles of multiply work left, whether an undelivered result exists,
  // and the output fields the unit should present.
  int          m_mul_left = 0;
  bit          m_have = 1'b0;
  bit          m_fresh = 1'b0;
  logic [31:0] m_res = '0, m_pend = '0;
  logic [3:0]  m_ctrl = '0;
  bit          m_ill = 1'b0, m_zero = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [2:0] f3,
                                        input logic f5, input logic f0);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b1111;
    if (f0) return (f3 == 3'b000) ? 4'b1010 : 4'b1111;
    if (f3 == 3'b000) return f5 ? 4'b0110 : 4'b0010;
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    if (f3 == 3'b100) return 4'b0111;
    if (f3 == 3'b001) return 4'b0011;
    if (f3 == 3'b101) return f5 ? 4'b0101 : 4'b0100;
    if (f3 == 3'b010) return 4'b1000;
    return 4'b1001;
  endfunction

  function automatic logic [31:0] compute(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return a ^ b;
      4'b0011: return a << sh;
      4'b0100: return a >> sh;
      4'b0101: return $unsigned($signed(a) >>> sh);
      4'b1000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: return (a < b) ? 32'd1 : 32'd0;
      4'b1010: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by the clock edge that just occurred, using the inputs held across it.
  task automatic model_step();
    bit rdy;
    logic [3:0] c;
    if (!rst_n) begin
      m_mul_left = 0; m_have = 0; m_fresh = 1;
      m_res = '0; m_ctrl = '0; m_ill = 0; m_zero = 0;
      return;
    end
    m_fresh = 0;
    rdy = (m_mul_left == 0) && (!m_have || out_ready);
    if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin
        m_have = 1; m_res = m_pend; m_zero = (m_pend == 0);
      end
    end else begin
      if (m_have && out_ready) m_have = 0;
      if (rdy && in_valid) begin
        c = decode(alu_op, funct3, funct7_5, funct7_0);
        m_ctrl = c;
        m_ill = (c == 4'b1111);
        if (c == 4'b1010) begin
          m_mul_left = 32;
          m_pend = compute(c, op_a, op_b);
        end else begin
          m_res = compute(c, op_a, op_b);
          m_zero = (m_res == 0);
          m_have = 1;
        end
      end
    end
  endtask

  task automatic compare();
    check("in_ready", 32'(in_ready), 32'((m_mul_left == 0) && (!m_have || out_ready)));
    check("out_valid", 32'(out_valid), 32'(m_have));
    check("busy", 32'(busy), 32'(m_mul_left > 0));
    if (m_have || m_fresh) begin
      check("result", result, m_res);
      check("zero", 32'(zero), 32'(m_zero));
      check("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      check("illegal", 32'(illegal), 32'(m_ill));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    compare();
  endtask

  task automatic set_op(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic f5, input logic f0, input logic [31:0] a,
                        input logic [31:0] b);
    in_valid = v; alu_op = op; funct3 = f3; funct7_5 = f5; funct7_0 = f0;
    op_a = a; op_b = b;
  endtask

  initial begin
    int lat, busy_cnt;
    bit seen;
    rst_n = 1'b0; out_ready = 1'b1;
    set_op(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(); tick();
    check("rst_result_lit", result, 32'd0);
    check("rst_outvalid_lit", 32'(out_valid), 32'd0);
    check("rst_busy_lit", 32'(busy), 32'd0);
    check("rst_zero_lit", 32'(zero), 32'd0);
    rst_n = 1'b1;
    tick();

    set_op(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7);
    tick();
    in_valid = 1'b0;
    check("add_valid_lit", 32'(out_valid), 32'd1);
    check("add_result_lit", result, 32'd12);
    check("add_ctrl_lit", 32'(alu_ctrl), 32'b0010);
    check("add_zero_lit", 32'(zero), 32'd0);
    tick();

    set_op(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h1234);
    tick();
    in_valid = 1'b0;
    check("sub_result_lit", result, 32'd0);
    check("sub_zero_lit", 32'(zero), 32'd1);
    check("sub_ctrl_lit", 32'(alu_ctrl), 32'b0110);
    tick();

    set_op(1'b1, 2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
    tick();
    in_valid = 1'b0;
    check("sra_result_lit", result, 32'hF800_0000);
    check("sra_ctrl_lit", 32'(alu_ctrl), 32'b0101);
    tick();

    // MUL; operands altered after accept must not matter.
    set_op(1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3);
    lat = 0; busy_cnt = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        check("mul_inready_lit", 32'(in_ready), 32'd0);
        op_a = 32'd0; op_b = 32'd0; in_valid = 1'b0;
      end
      if (busy) busy_cnt++;
    end while (!out_valid && lat < 40);
    check("mul_latency_lit", 32'(lat), 32'd33);
    check("mul_busy_cycles_lit", 32'(busy_cnt), 32'd32);
    check("mul_result_lit", result, 32'hFFFF_FFFD);
    check("mul_ctrl_lit", 32'(alu_ctrl), 32'b1010);
    tick();

    // Stall the consumer, then stream three ADDs.
    out_ready = 1'b0;
    set_op(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2);
    tick();
    op_a = 32'd10; op_b = 32'd20;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_result_lit", result, 32'd3);
      check("stall_inready_lit", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("b2b0_lit", result, 32'd30);
    op_a = 32'd100; op_b = 32'd1;
    tick();
    check("b2b1_lit", result, 32'd101);
    check("b2b1_valid_lit", 32'(out_valid), 32'd1);
    op_a = 32'd7; op_b = 32'd8;
    tick();
    check("b2b2_lit", result, 32'd15);
    check("b2b2_valid_lit", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();

    // Abort a MUL with reset at its 10th cycle.
    set_op(1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 32'd6, 32'd7);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy_lit", 32'(busy), 32'd0);
    check("abort_valid_lit", 32'(out_valid), 32'd0);
    check("abort_result_lit", result, 32'd0);
    check("abort_ctrl_lit", 32'(alu_ctrl), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output_lit", 32'(seen), 32'd0);

    set_op(1'b1, 2'b11, 3'b000, 1'b0, 1'b0, 32'd5, 32'd9);
    tick();
    in_valid = 1'b0;
    check("ill_flag_lit", 32'(illegal), 32'd1);
    check("ill_result_lit", result, 32'd0);
    check("ill_ctrl_lit", 32'(alu_ctrl), 32'b1111);
    check("ill_zero_lit", 32'(zero), 32'd1);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 9) < 6);
      alu_op    = 2'($urandom_range(0, 3));
      funct3    = 3'($urandom_range(0, 7));
      funct7_5  = 1'($urandom_range(0, 1));
      funct7_0  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        alu_op = 2'b10; funct3 = 3'b000; funct7_0 = 1'b1;
      end
      op_a = $urandom();
      op_b = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 40));
      if ($urandom_range(0, 15) == 0) op_a = 32'h8000_0000;
      if ($urandom_range(0, 15) == 0) op_b = op_a;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
